fp16_invsqrt_sched: RTL and testbench

Round-robin scheduler that shares one fp16 inverse-square-root datapath between N_REQ requesters. It accepts operands over per-requester valid/ready handshakes and issues at most one operand per cycle into the shared unit. It tracks each in-flight operation through a LAT-deep tag pipeline and returns each result to the requester that issued it through a held response register. It sits between the client blocks and the `fp16_invsqrt` datapath, or a pipelined variant of it.

---
 rtl/fp16_invsqrt_sched_if.sv | 22 ++
 rtl/fp16_invsqrt_sched.sv | 137 +++++++++++++
 tb/tb_fp16_invsqrt_sched.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_invsqrt_sched_if.sv
`timescale 1ns/1ps
// Request/response bundle between client blocks and the fp16 inverse-square-root scheduler.
interface fp16_invsqrt_sched_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [16*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    rsp_valid;
  logic [N_REQ-1:0]    rsp_ready;
  logic [16*N_REQ-1:0] rsp_data;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/fp16_invsqrt_sched.sv
`timescale 1ns/1ps
// Round-robin scheduler sharing one fp16 inverse-square-root unit among N_REQ requesters,
// with a LAT-deep tag pipeline routing each result back into a held per-requester response.
module fp16_invsqrt_sched #(
  parameter int N_REQ = 4,
  parameter int LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_enable,
  fp16_invsqrt_sched_if.slave bus,
  output logic [15:0]         unit_in,
  input  logic [15:0]         unit_out,
  output logic                busy,
  output logic [15:0]         issue_cnt
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_INFLIGHT = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;

  // (base + off) mod N_REQ; both operands are below N_REQ so one subtraction suffices.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'({{(32-PTR_W){1'b0}}, base}) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[PTR_W-1:0];
  endfunction

  logic [1:0]       state_q    [N_REQ];
  logic [1:0]       state_d    [N_REQ];
  logic [15:0]      rsp_data_q [N_REQ];
  logic [15:0]      rsp_data_d [N_REQ];
  logic [PTR_W-1:0] tag_id_q   [LAT];
  logic [PTR_W-1:0] tag_id_d   [LAT];
  logic [LAT-1:0]   tag_vld_q, tag_vld_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [15:0]      unit_in_q, unit_in_d;
  logic [15:0]      issue_cnt_q, issue_cnt_d;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic             issue;
  logic [PTR_W-1:0] issue_id;
  logic             retire;
  logic [PTR_W-1:0] retire_id;
  logic             any_active;

  // Grant stage: rotating priority search starting at rr_ptr; reset suppresses grants.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = ~rst & cfg_enable & bus.req_valid[i] & (state_q[i] == ST_IDLE);
    end
    grant    = '0;
    issue    = 1'b0;
    issue_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!issue && eligible[ptr_add(rr_ptr_q, k)]) begin
        grant[ptr_add(rr_ptr_q, k)] = 1'b1;
        issue                       = 1'b1;
        issue_id                    = ptr_add(rr_ptr_q, k);
      end
    end
  end

  assign retire    = tag_vld_q[LAT-1];
  assign retire_id = tag_id_q[LAT-1];

  // Issue/retire stage: operand capture, tag shift and per-requester state update.
  always_comb begin
    unit_in_d   = unit_in_q;
    rr_ptr_d    = rr_ptr_q;
    issue_cnt_d = issue_cnt_q;
    if (issue) begin
      rr_ptr_d    = ptr_add(issue_id, 1);
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) unit_in_d = bus.req_data[16*i +: 16];
    end

    tag_vld_d[0] = issue;
    tag_id_d[0]  = issue_id;
    for (int s = 1; s < LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end

    any_active = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      state_d[i]    = state_q[i];
      rsp_data_d[i] = rsp_data_q[i];
      if (grant[i]) state_d[i] = ST_INFLIGHT;
      if (retire && (retire_id == PTR_W'(i))) begin
        state_d[i]    = ST_HOLD;
        rsp_data_d[i] = unit_out;
      end
      if ((state_q[i] == ST_HOLD) && bus.rsp_ready[i]) state_d[i] = ST_IDLE;
      if (state_q[i] != ST_IDLE) any_active = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        state_q[i]    <= ST_IDLE;
        rsp_data_q[i] <= '0;
      end
      tag_vld_q   <= '0;
      rr_ptr_q    <= '0;
      unit_in_q   <= '0;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_data_q  <= rsp_data_d;
      tag_vld_q   <= tag_vld_d;
      rr_ptr_q    <= rr_ptr_d;
      unit_in_q   <= unit_in_d;
      issue_cnt_q <= issue_cnt_d;
    end
    tag_id_q <= tag_id_d;
  end

  // Output stage: response valid is the HOLD state itself, so data and valid move together.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      bus.rsp_valid[i]         = (state_q[i] == ST_HOLD);
      bus.rsp_data[16*i +: 16] = rsp_data_q[i];
    end
  end

  assign bus.req_ready = grant;
  assign unit_in       = unit_in_q;
  assign issue_cnt     = issue_cnt_q;
  assign busy          = (|tag_vld_q) | any_active;
endmodule

// File: tb/tb_fp16_invsqrt_sched.sv
`timescale 1ns/1ps
// Bench for fp16_invsqrt_sched: one LAT=1 instance and one LAT=3 instance, each fed by a
// bitwise-NOT stand-in for the shared datapath.
module tb_fp16_invsqrt_sched;
  typedef struct {
    int          id;
    logic [15:0] op;
    logic [15:0] res;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg1, cfg3;
  logic [15:0] u1_in, u1_out, u3_in, u3_out, cnt1, cnt3;
  logic        busy1, busy3;
  logic [15:0] m1, m2;

  int n_pass = 0;
  int n_tot  = 0;

  fp16_invsqrt_sched_if #(.N_REQ(4)) i1 ();
  fp16_invsqrt_sched_if #(.N_REQ(4)) i3 ();

  fp16_invsqrt_sched #(.N_REQ(4), .LAT(1)) dut1 (
    .clk(clk), .rst(rst), .cfg_enable(cfg1), .bus(i1),
    .unit_in(u1_in), .unit_out(u1_out), .busy(busy1), .issue_cnt(cnt1)
  );

  fp16_invsqrt_sched #(.N_REQ(4), .LAT(3)) dut3 (
    .clk(clk), .rst(rst), .cfg_enable(cfg3), .bus(i3),
    .unit_in(u3_in), .unit_out(u3_out), .busy(busy3), .issue_cnt(cnt3)
  );

  always #5 clk = ~clk;

  assign u1_out = ~u1_in;
  always @(posedge clk) begin
    m1 <= ~u3_in;
    m2 <= m1;
  end
  assign u3_out = m2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    cfg1         = 1'b0;
    cfg3         = 1'b0;
    i1.req_valid = '0; i1.req_data = '0; i1.rsp_ready = '0;
    i3.req_valid = '0; i3.req_data = '0; i3.rsp_ready = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t        vecs [7];
    logic [15:0] t2_res [4];
    logic [3:0]  exp_g, exp_v;
    logic [15:0] exp_u;
    int          id, bad, bad_oh, late2, held_bad, gcount, cyc;
    int          gc [4];

    vecs[0] = '{0, 16'h4400, 16'hBBFF};
    vecs[1] = '{1, 16'h3C00, 16'hC3FF};
    vecs[2] = '{2, 16'h7C00, 16'h83FF};
    vecs[3] = '{3, 16'h7E00, 16'h81FF};
    vecs[4] = '{1, 16'h0000, 16'hFFFF};
    vecs[5] = '{0, 16'hBC00, 16'h43FF};
    vecs[6] = '{2, 16'hFFFF, 16'h0000};
    t2_res  = '{16'hC3FF, 16'hC3FE, 16'hC3FD, 16'hC3FC};

    // Reset state of both instances
    do_reset();
    #1;
    chk("rst_req_ready1", 32'(i1.req_ready), 32'h0);
    chk("rst_rsp_valid1", 32'(i1.rsp_valid), 32'h0);
    chk("rst_unit_in1",   32'(u1_in),        32'h0);
    chk("rst_issue_cnt1", 32'(cnt1),         32'h0);
    chk("rst_busy1",      32'(busy1),        32'h0);
    chk("rst_rsp_valid3", 32'(i3.rsp_valid), 32'h0);
    chk("rst_rsp_data3",  32'(i3.rsp_data[31:0]), 32'h0);
    chk("rst_busy3",      32'(busy3),        32'h0);

    // Table-driven single requests on the LAT=1 instance
    cfg1 = 1'b1;
    for (int v = 0; v < 7; v++) begin
      id = vecs[v].id;
      @(negedge clk);
      i1.req_valid = 4'(1 << id);
      i1.req_data[16*id +: 16] = vecs[v].op;
      #1;
      chk("t1_grant", 32'(i1.req_ready), 32'(1 << id));
      @(negedge clk);
      i1.req_valid = '0;
      #1;
      chk("t1_unit_in", 32'(u1_in), 32'(vecs[v].op));
      chk("t1_no_early_rsp", 32'(i1.rsp_valid), 32'h0);
      chk("t1_busy", 32'(busy1), 32'h1);
      @(negedge clk);
      #1;
      chk("t1_rsp_valid", 32'(i1.rsp_valid), 32'(1 << id));
      chk("t1_rsp_data", 32'(i1.rsp_data[16*id +: 16]), 32'(vecs[v].res));
      i1.rsp_ready = 4'(1 << id);
      @(negedge clk);
      #1;
      chk("t1_rsp_clear", 32'(i1.rsp_valid), 32'h0);
      chk("t1_issue_cnt", 32'(cnt1), 32'(v + 1));
      i1.rsp_ready = '0;
    end

    // All four requesters valid from reset, LAT=3
    do_reset();
    i3.req_valid = 4'hF;
    i3.req_data  = {16'h3C03, 16'h3C02, 16'h3C01, 16'h3C00};
    i3.rsp_ready = 4'hF;
    cfg3         = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_g = ((c % 5) < 4) ? 4'(1 << (c % 5)) : 4'b0;
      chk("t2_grant", 32'(i3.req_ready), 32'(exp_g));
      exp_v = '0;
      for (int i = 0; i < 4; i++) if ((c >= 4 + i) && (((c - 4 - i) % 5) == 0)) exp_v[i] = 1'b1;
      chk("t2_rsp_valid", 32'(i3.rsp_valid), 32'(exp_v));
      for (int i = 0; i < 4; i++)
        if (exp_v[i]) chk("t2_rsp_data", 32'(i3.rsp_data[16*i +: 16]), 32'(t2_res[i]));
      if (c == 0) exp_u = 16'h0000;
      else if (((c - 1) % 5) < 4) exp_u = 16'h3C00 + 16'((c - 1) % 5);
      else exp_u = 16'h3C03;
      chk("t2_unit_in", 32'(u3_in), 32'(exp_u));
    end

    // Backpressure on requester 2
    do_reset();
    i3.req_valid = 4'hF;
    i3.req_data  = {16'h3C03, 16'h3C02, 16'h3C01, 16'h3C00};
    i3.rsp_ready = 4'b1011;
    cfg3         = 1'b1;
    bad_oh = 0; late2 = 0; held_bad = 0;
    for (int i = 0; i < 4; i++) gc[i] = 0;
    for (int c = 0; c < 26; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if ($countones(i3.req_ready) > 1) bad_oh++;
      for (int i = 0; i < 4; i++) if (i3.req_ready[i]) gc[i]++;
      if ((c > 2) && i3.req_ready[2]) late2++;
      if ((c >= 6) && (!i3.rsp_valid[2] || (i3.rsp_data[47:32] != 16'hC3FD))) held_bad++;
    end
    chk("t3_onehot", 32'(bad_oh), 32'h0);
    chk("t3_no_grant_while_held", 32'(late2), 32'h0);
    chk("t3_held_stable", 32'(held_bad), 32'h0);
    chk("t3_grants_r2", 32'(gc[2]), 32'h1);
    chk("t3_rr_r0", 32'(gc[0] >= 4), 32'h1);
    chk("t3_rr_r1", 32'(gc[1] >= 4), 32'h1);
    chk("t3_rr_r3", 32'(gc[3] >= 4), 32'h1);
    @(negedge clk);
    i3.req_valid        = 4'b0100;
    i3.req_data[47:32]  = 16'h1234;
    i3.rsp_ready        = 4'hF;
    #1;
    chk("t3_no_rsp_to_req_path", 32'(i3.req_ready), 32'h0);
    @(negedge clk);
    #1;
    chk("t3_released", 32'(i3.rsp_valid[2]), 32'h0);
    chk("t3_regrant", 32'(i3.req_ready), 32'h4);
    @(negedge clk);
    #1;
    chk("t3_unit_in", 32'(u3_in), 32'h1234);

    // cfg_enable drop with three operations in flight
    do_reset();
    i3.req_valid = 4'hF;
    i3.req_data  = {16'h5003, 16'h5002, 16'h5001, 16'h5000};
    cfg3         = 1'b1;
    #1;
    chk("t4_grant0", 32'(i3.req_ready), 32'h1);
    @(negedge clk); #1;
    chk("t4_grant1", 32'(i3.req_ready), 32'h2);
    @(negedge clk); #1;
    chk("t4_grant2", 32'(i3.req_ready), 32'h4);
    @(negedge clk);
    cfg3 = 1'b0;
    #1;
    chk("t4_disabled", 32'(i3.req_ready), 32'h0);
    bad = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (i3.req_ready != 4'b0) bad++;
    end
    chk("t4_no_grant_drain", 32'(bad), 32'h0);
    chk("t4_rsp_valid", 32'(i3.rsp_valid), 32'h7);
    chk("t4_rsp_data0", 32'(i3.rsp_data[15:0]),  32'hAFFF);
    chk("t4_rsp_data1", 32'(i3.rsp_data[31:16]), 32'hAFFE);
    chk("t4_rsp_data2", 32'(i3.rsp_data[47:32]), 32'hAFFD);
    chk("t4_busy_held", 32'(busy3), 32'h1);
    i3.rsp_ready = 4'b0111;
    @(negedge clk); #1;
    chk("t4_rsp_clear", 32'(i3.rsp_valid), 32'h0);
    chk("t4_busy_idle", 32'(busy3), 32'h0);
    i3.rsp_ready = '0;
    cfg3 = 1'b1;
    #1;
    chk("t4_resume_rr", 32'(i3.req_ready), 32'h8);

    // Reset pulse with two in flight and one held
    do_reset();
    i3.req_valid = 4'b0111;
    i3.req_data  = {16'h0000, 16'h6002, 16'h6001, 16'h6000};
    cfg3         = 1'b1;
    #1;
    chk("t5_grant0", 32'(i3.req_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    i3.req_valid = '0;
    @(negedge clk); #1;
    chk("t5_held_before_rst", 32'(i3.rsp_valid), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_rsp_valid", 32'(i3.rsp_valid), 32'h0);
    chk("t5_rsp_data0", 32'(i3.rsp_data[15:0]), 32'h0);
    chk("t5_unit_in", 32'(u3_in), 32'h0);
    chk("t5_issue_cnt", 32'(cnt3), 32'h0);
    chk("t5_busy", 32'(busy3), 32'h0);
    chk("t5_req_ready", 32'(i3.req_ready), 32'h0);
    bad = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (i3.rsp_valid != 4'b0) bad++;
    end
    chk("t5_discarded", 32'(bad), 32'h0);

    // issue_cnt wrap after 65537 issues on the LAT=1 instance
    do_reset();
    i1.req_valid = 4'hF;
    i1.req_data  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    i1.rsp_ready = 4'hF;
    cfg1         = 1'b1;
    gcount = 0;
    cyc    = 0;
    while ((gcount < 65537) && (cyc < 70000)) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (gcount == 65535) chk("t6_cnt_ffff", 32'(cnt1), 32'hFFFF);
      if (i1.req_ready != 4'b0) gcount++;
      cyc++;
    end
    chk("t6_grant_count", 32'(gcount), 32'(65537));
    @(negedge clk);
    i1.req_valid = '0;
    #1;
    chk("t6_wrap", 32'(cnt1), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
